spi_slave_regif: RTL and testbench
==================================

SPI_SLAVE_REGIF -- requirements
Module: spi_slave_regif

Interface
REQ-001 SHALL have parameter STATUS_BYTE, default 8'hA5, the byte shifted out on MISO during command byte.
REQ-002 SHALL have parameter MIN_HALF, default 4, the minimum SCLK half-period in clk cycles that the block supports.
REQ-003 SHALL have port clk, input, 1, system clock (12 MHz).
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port spi_clk, input, 1, SPI SCLK; asynchronous to clk; idles low.
REQ-006 SHALL have port spi_mosi, input, 1, master-out data.
REQ-007 SHALL have port spi_cs, input, 1, chip select, active low.
REQ-008 SHALL have port spi_miso, output, 1, slave-out data.
REQ-009 SHALL have port reg_addr, output, 7, register address.
REQ-010 SHALL have port reg_wdata, output, 8, write data.
REQ-011 SHALL have port reg_we, output, 1, one-cycle write strobe.
REQ-012 SHALL have port reg_re, output, 1, one-cycle read strobe.
REQ-013 SHALL have port reg_rdata, input, 8, read data, valid 1 clk after reg_re.
REQ-014 SHALL have port frame_err, output, 1, one-cycle pulse on a short frame.
REQ-015 SHALL have port busy, output, 1, high while a frame is in progress.

Function
REQ-016 SHALL pass spi_clk, spi_mosi and spi_cs through 2-FF synchronizers, then detect edges in the clk domain.
REQ-017 SHALL sample MOSI on each detected SCLK falling edge and shift MISO on each detected rising edge, MSB first.
REQ-018 SHALL use a frame of three bytes with CS low: byte0 = {rw, addr[6:0]} (rw=1 read); byte1 = data; byte2 = checksum.
REQ-019 SHALL load STATUS_BYTE into the TX shifter on CS falling, with its MSB driven on MISO within 3 clk.
REQ-020 SHALL register addr on the 8th falling edge; if rw=1, it SHALL pulse reg_re, capture reg_rdata the next cycle, and load it into the TX shifter before the 9th rising edge.
REQ-021 SHALL, if rw=0, drive MISO 0 during byte1.
REQ-022 SHALL, if rw=0, pulse reg_we exactly once on the 16th falling edge, with reg_addr and reg_wdata valid in the same cycle.
REQ-023 SHALL drive byte2 on MISO as byte0 XOR byte1-field, where byte1-field = received byte (write) or transmitted byte (read).
REQ-024 SHALL use states IDLE -> CMD -> DATA -> TRAIL -> DONE, plus WAIT_CS.
REQ-025 SHALL enter CMD on CS falling.
REQ-026 SHALL advance CMD->DATA, DATA->TRAIL and TRAIL->DONE on every 8 bits.
REQ-027 SHALL return to IDLE from any state when CS rises.
REQ-028 SHALL, in DONE (bits beyond 24), ignore MOSI, hold MISO 0, and issue no strobes.
REQ-029 SHALL pulse frame_err when CS rises with 1..23 bits received.
REQ-030 SHALL NOT pulse frame_err when CS rises with 0 or ≥24 bits received.
REQ-031 SHALL keep a write that has already been strobed (≥16 bits) even if frame_err follows.
REQ-032 SHALL drive MISO 0 whenever CS is high.
REQ-033 SHALL assert busy from CS-low detection to CS-high detection.
REQ-034 SHALL, if CS rises on the same clk as a SCLK edge, let the CS rise win and discard the edge.
REQ-035 SHALL keep the bit counter 5 bits wide, saturating at 24.

Reset
REQ-036 SHALL, on rst, reset spi_miso, reg_we, reg_re, frame_err, busy, reg_addr, reg_wdata, shifters and counter to 0.
REQ-037 SHALL, on rst, reset the synchronizers to idle (SCLK 0, CS 1).
REQ-038 SHALL, on rst release with CS low, enter WAIT_CS: ignore the rest of the frame, issue no strobes or frame_err, and go to IDLE on CS high.

Structure
REQ-039 SHALL take the state encoding, STATUS_BYTE default and byte/bit count constants from shared package spi_pkg.
REQ-040 SHALL implement the synchronizer plus edge detect as sub-module spi_sync, instantiated per input.

Verification
REQ-041 Write 0x01,0x05,0x00 -> one reg_we with addr 0x01, wdata 0x05; MISO byte0=0xA5, byte1=0x00, byte2=0x04; no frame_err.
REQ-042 Read 0x81,0x00,0x00 with reg_rdata=0x3C -> one reg_re with addr 0x01; MISO byte1=0x3C, byte2=0xBD; no reg_we.
REQ-043 CS high after 12 bits of 0x02,0x7x -> frame_err one pulse, no strobes; next full frame succeeds.
REQ-044 rst pulsed at bit 5 of a frame with CS held low -> no strobes or frame_err for that frame; next frame writes correctly.
REQ-045 Back-to-back writes, byte1 cycling 0x01..0x0F then addr 0x02 data 0x00, at SCLK half-period = MIN_HALF -> every strobe matches its frame.
REQ-046 Four-byte frame -> MISO 0 during byte3; exactly one strobe; no frame_err.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants for the SPI slave register interface:
//                state encoding, default status byte and frame geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    // Byte presented on MISO while the command byte is being received
    localparam logic [7:0] c_STATUS_BYTE_DEFAULT = 8'hA5;

    // Frame geometry: three bytes of eight bits each
    localparam int unsigned c_BYTE_BITS   = 8;
    localparam int unsigned c_FRAME_BYTES = 3;

    // Bit-counter values (counter holds the number of bits already received)
    localparam logic [4:0] c_CMD_LAST   = 5'(c_BYTE_BITS - 1);
    localparam logic [4:0] c_DATA_LAST  = 5'(2 * c_BYTE_BITS - 1);
    localparam logic [4:0] c_TRAIL_LAST = 5'(3 * c_BYTE_BITS - 1);
    localparam logic [4:0] c_FRAME_BITS = 5'(c_FRAME_BYTES * c_BYTE_BITS);

    // Frame state machine encoding
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_CMD     = 3'd1;
    localparam logic [2:0] c_ST_DATA    = 3'd2;
    localparam logic [2:0] c_ST_TRAIL   = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;
    localparam logic [2:0] c_ST_WAIT_CS = 3'd5;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync
//  Description : Two-flop synchronizer for one asynchronous SPI pin, followed
//                by a history flop that yields single-cycle rise/fall pulses
//                in the clk domain.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resynchronise the pin and keep one cycle of history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule : spi_sync
`default_nettype wire

// File: rtl/spi_slave_regif.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_regif
//  Description : SPI slave (SCLK idles low, MOSI sampled on falling edges,
//                MISO changed on rising edges, MSB first) that turns a
//                three-byte frame {rw,addr} / data / checksum into one-cycle
//                register read or write strobes in the clk domain.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave_regif
    import spi_pkg::*;
#(
    parameter logic [7:0]  STATUS_BYTE = c_STATUS_BYTE_DEFAULT,
    parameter int unsigned MIN_HALF    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs,
    output logic       spi_miso,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_err,
    output logic       busy
);

    // Read data arrives two cycles after the 8th falling edge is seen, so the
    // next rising edge must be at least that far away.
    if (MIN_HALF < 4) begin : g_min_half_check
        $error("spi_slave_regif: MIN_HALF must be at least 4");
    end

    // ------------------------------------------------------------------------
    // Pin synchronisation
    // ------------------------------------------------------------------------
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_mosi,     w_mosi_rise, w_mosi_fall;
    logic w_cs_lvl,   w_cs_rise,   w_cs_fall;
    logic w_unused_sync;

    spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .async_i(spi_clk),
        .sync_o (w_sclk_lvl),
        .rise_o (w_sclk_rise),
        .fall_o (w_sclk_fall)
    );

    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .async_i(spi_mosi),
        .sync_o (w_mosi),
        .rise_o (w_mosi_rise),
        .fall_o (w_mosi_fall)
    );

    spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .async_i(spi_cs),
        .sync_o (w_cs_lvl),
        .rise_o (w_cs_rise),
        .fall_o (w_cs_fall)
    );

    assign w_unused_sync = w_sclk_lvl ^ w_mosi_rise ^ w_mosi_fall ^ w_cs_lvl;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0] state_q, state_d;
    logic [4:0] cnt_q;
    logic [1:0] settle_q;
    logic [7:0] rx_q;
    logic [7:0] tx_q;
    logic [7:0] cmd_q;
    logic [7:0] byte1_q;
    logic       miso_q;
    logic [6:0] reg_addr_q;
    logic [7:0] reg_wdata_q;
    logic       reg_we_q;
    logic       reg_re_q;
    logic       rd_cap_q;
    logic       frame_err_q;

    logic       w_in_frame;
    logic       w_shifting;
    logic       w_settled;
    logic       w_start;
    logic [7:0] w_rx_byte;

    // A CS fall seen before the synchronizers have flushed after reset means
    // CS was already low: that frame is joined mid-way and must be ignored.
    assign w_settled = (settle_q == 2'd3);
    assign w_start   = (state_q == c_ST_IDLE) && w_cs_fall && w_settled;
    assign w_rx_byte = {rx_q[6:0], w_mosi};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a CS rise overrides any SCLK edge in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_cs_fall) begin
                    state_d = w_settled ? c_ST_CMD : c_ST_WAIT_CS;
                end
            end
            c_ST_CMD: begin
                if (w_cs_rise) begin
                    state_d = c_ST_IDLE;
                end else if (w_sclk_fall && (cnt_q == c_CMD_LAST)) begin
                    state_d = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_cs_rise) begin
                    state_d = c_ST_IDLE;
                end else if (w_sclk_fall && (cnt_q == c_DATA_LAST)) begin
                    state_d = c_ST_TRAIL;
                end
            end
            c_ST_TRAIL: begin
                if (w_cs_rise) begin
                    state_d = c_ST_IDLE;
                end else if (w_sclk_fall && (cnt_q == c_TRAIL_LAST)) begin
                    state_d = c_ST_DONE;
                end
            end
            c_ST_DONE, c_ST_WAIT_CS: begin
                if (w_cs_rise) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // State decode: which states belong to a live frame and which shift data
    always_comb begin
        w_in_frame = 1'b0;
        w_shifting = 1'b0;
        case (state_q)
            c_ST_CMD, c_ST_DATA, c_ST_TRAIL: begin
                w_in_frame = 1'b1;
                w_shifting = 1'b1;
            end
            c_ST_DONE: begin
                w_in_frame = 1'b1;
            end
            default: begin
                w_in_frame = 1'b0;
                w_shifting = 1'b0;
            end
        endcase
    end

    // Shifters, bit counter, strobes and MISO driver
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q    <= 2'd0;
            cnt_q       <= 5'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            cmd_q       <= 8'h00;
            byte1_q     <= 8'h00;
            miso_q      <= 1'b0;
            reg_addr_q  <= 7'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            rd_cap_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rd_cap_q    <= reg_re_q;
            if (!w_settled) begin
                settle_q <= settle_q + 2'd1;
            end

            if (w_start) begin
                cnt_q  <= 5'd0;
                rx_q   <= 8'h00;
                tx_q   <= STATUS_BYTE;
                miso_q <= STATUS_BYTE[7];
            end else if (w_in_frame && w_cs_rise) begin
                miso_q      <= 1'b0;
                frame_err_q <= (cnt_q != 5'd0) && (cnt_q < c_FRAME_BITS);
            end else if (w_in_frame) begin
                // Read data is valid the cycle after reg_re; it becomes byte1
                if (rd_cap_q && w_shifting) begin
                    tx_q    <= reg_rdata;
                    byte1_q <= reg_rdata;
                end

                if (w_sclk_rise) begin
                    miso_q <= w_shifting ? tx_q[7] : 1'b0;
                end

                if (w_sclk_fall) begin
                    cnt_q <= (cnt_q == c_FRAME_BITS) ? cnt_q : cnt_q + 5'd1;
                end

                if (w_sclk_fall && w_shifting) begin
                    rx_q <= w_rx_byte;
                    tx_q <= {tx_q[6:0], 1'b0};
                    if (cnt_q == c_CMD_LAST) begin
                        cmd_q      <= w_rx_byte;
                        reg_addr_q <= w_rx_byte[6:0];
                        tx_q       <= 8'h00;
                        if (w_rx_byte[7]) begin
                            reg_re_q <= 1'b1;
                        end
                    end else if (cnt_q == c_DATA_LAST) begin
                        if (!cmd_q[7]) begin
                            reg_wdata_q <= w_rx_byte;
                            reg_we_q    <= 1'b1;
                            tx_q        <= cmd_q ^ w_rx_byte;
                        end else begin
                            tx_q <= cmd_q ^ byte1_q;
                        end
                    end else if (cnt_q == c_TRAIL_LAST) begin
                        tx_q <= 8'h00;
                    end
                end
            end else begin
                miso_q <= 1'b0;
            end
        end
    end

    assign spi_miso  = miso_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign frame_err = frame_err_q;
    assign busy      = w_in_frame;

endmodule : spi_slave_regif
`default_nettype wire

// File: tb/tb_spi_slave_regif.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_regif
//  Description : Directed and randomised SPI frames against a frame-level
//                model of the register interface.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_slave_regif;

    localparam logic [7:0] c_STATUS = 8'hA5;
    localparam int         c_HALF   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_cs;
    logic       spi_miso;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       frame_err;
    logic       busy;

    logic [7:0] mem [128];

    int checks = 0;
    int errors = 0;
    int we_cnt, re_cnt, fe_cnt;
    logic [6:0] we_addr, re_addr;
    logic [7:0] we_data;

    always #42 clk = ~clk;

    spi_slave_regif #(
        .STATUS_BYTE(c_STATUS),
        .MIN_HALF   (c_HALF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_cs   (spi_cs),
        .spi_miso (spi_miso),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // Register-file responder and strobe recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt++;
            we_addr = reg_addr;
            we_data = reg_wdata;
        end
        if (reg_re) begin
            re_cnt++;
            re_addr   = reg_addr;
            reg_rdata = mem[reg_addr];
        end
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame of nbits (MSB of 'bits' first); optionally pulse rst
    // before bit rst_at. Returns what was seen on MISO at each falling edge.
    task automatic drive_frame(input logic [31:0] bits, input int nbits, input int half,
                               input int rst_at, output logic [31:0] miso_bits);
        miso_bits = '0;
        spi_cs = 1'b0;
        tick(3);
        check("miso_msb_3clk", {31'd0, spi_miso}, {31'd0, c_STATUS[7]});
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        tick(half);
        for (int k = 0; k < nbits; k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
                tick(half);
            end
            spi_mosi = bits[31-k];
            spi_clk  = 1'b1;
            tick(half);
            miso_bits[31-k] = spi_miso;
            spi_clk = 1'b0;
            tick(half);
        end
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        tick(6);
        check("busy_after_cs", {31'd0, busy}, 32'd0);
    endtask

    // Frame-level model: what the slave must answer and which strobes result
    task automatic run_frame(input logic [31:0] bits, input int nbits, input int half,
                             input int rst_at);
        logic [7:0]  b0, b1, field;
        logic [31:0] seen;
        logic [7:0]  exp_byte [4];
        logic        is_rd, aborted;
        int          exp_we, exp_re, exp_fe;
        b0      = bits[31:24];
        b1      = bits[23:16];
        is_rd   = b0[7];
        aborted = (rst_at >= 0);
        field   = is_rd ? mem[b0[6:0]] : b1;
        exp_byte[0] = c_STATUS;
        exp_byte[1] = is_rd ? mem[b0[6:0]] : 8'h00;
        exp_byte[2] = b0 ^ field;
        exp_byte[3] = 8'h00;
        exp_we = (!aborted && !is_rd && nbits >= 16) ? 1 : 0;
        exp_re = (!aborted &&  is_rd && nbits >= 8)  ? 1 : 0;
        exp_fe = (!aborted && nbits >= 1 && nbits < 24) ? 1 : 0;
        we_cnt = 0;
        re_cnt = 0;
        fe_cnt = 0;
        drive_frame(bits, nbits, half, rst_at, seen);
        if (!aborted) begin
            for (int i = 0; i < nbits / 8; i++) begin
                check($sformatf("miso_byte%0d_cmd%02h", i, b0), {24'd0, seen[31-8*i -: 8]},
                      {24'd0, exp_byte[i]});
            end
        end
        check($sformatf("we_count_cmd%02h_n%0d", b0, nbits), we_cnt, exp_we);
        check($sformatf("re_count_cmd%02h_n%0d", b0, nbits), re_cnt, exp_re);
        check($sformatf("frame_err_cmd%02h_n%0d", b0, nbits), fe_cnt, exp_fe);
        if (exp_we == 1) begin
            check("we_addr", {25'd0, we_addr}, {25'd0, b0[6:0]});
            check("we_data", {24'd0, we_data}, {24'd0, b1});
            mem[b0[6:0]] = b1;
        end
        if (exp_re == 1) begin
            check("re_addr", {25'd0, re_addr}, {25'd0, b0[6:0]});
        end
    endtask

    initial begin
        logic [7:0] a, d;
        int         n, h;
        rst       = 1'b1;
        spi_clk   = 1'b0;
        spi_mosi  = 1'b0;
        spi_cs    = 1'b1;
        reg_rdata = 8'h00;
        we_cnt = 0; re_cnt = 0; fe_cnt = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 11);

        tick(3);
        check("rst_miso",      {31'd0, spi_miso},  32'd0);
        check("rst_we",        {31'd0, reg_we},    32'd0);
        check("rst_re",        {31'd0, reg_re},    32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_addr",      {25'd0, reg_addr},  32'd0);
        check("rst_wdata",     {24'd0, reg_wdata}, 32'd0);
        rst = 1'b0;
        tick(6);

        // Basic write and read
        run_frame({8'h01, 8'h05, 8'h00, 8'h00}, 24, c_HALF, -1);
        mem[1] = 8'h3C;
        run_frame({8'h81, 8'h00, 8'h00, 8'h00}, 24, c_HALF, -1);

        // Short frame, then a good one
        run_frame({8'h02, 8'h7A, 8'h00, 8'h00}, 12, c_HALF, -1);
        run_frame({8'h02, 8'h33, 8'h00, 8'h00}, 24, c_HALF, -1);
        run_frame({8'h82, 8'h00, 8'h00, 8'h00}, 24, c_HALF, -1);

        // Empty frame: no error
        run_frame(32'h0, 0, c_HALF, -1);

        // Reset in the middle of a frame with CS held low
        run_frame({8'h05, 8'h44, 8'h00, 8'h00}, 24, c_HALF, 5);
        run_frame({8'h05, 8'h44, 8'h00, 8'h00}, 24, c_HALF, -1);
        run_frame({8'h85, 8'h00, 8'h00, 8'h00}, 24, c_HALF, -1);

        // Back-to-back writes at the fastest supported SCLK
        for (int v = 1; v <= 15; v++) begin
            run_frame({8'h02, 8'(v), 8'h00, 8'h00}, 24, c_HALF, -1);
        end
        run_frame({8'h02, 8'h00, 8'h00, 8'h00}, 24, c_HALF, -1);
        run_frame({8'h82, 8'h00, 8'h00, 8'h00}, 24, c_HALF, -1);

        // Four-byte frames: trailing byte reads back as zero
        run_frame({8'h10, 8'h99, 8'h89, 8'hFF}, 32, c_HALF, -1);
        run_frame({8'h90, 8'h00, 8'h00, 8'hFF}, 32, c_HALF, -1);

        // Randomised frames over a small address window
        for (int r = 0; r < 40; r++) begin
            a = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) a = a | 8'h80;
            d = 8'($urandom);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : 24;
            h = int'($urandom_range(c_HALF, c_HALF + 3));
            run_frame({a, d, 8'($urandom), 8'($urandom)}, n, h, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spi_slave_regif
`default_nettype wire
